// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared state encoding and image geometry defaults for the anchor sequencer
package edge_pkg;

   localparam int DEF_IMAGE_W = 640;
   localparam int DEF_IMAGE_H = 480;
   localparam int DEF_STEP    = 16;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_LOAD        = 3'd1,
      S_MOVE        = 3'd2,
      S_GUARD       = 3'd3,
      S_WAIT_STAGES = 3'd4,
      S_DONE        = 3'd5
   } anchor_state_t;

endpackage

// File: rtl/anchor_sequencer_if.sv
// rtl/anchor_sequencer_if.sv - control/handshake bundle between a pass controller and the anchor sequencer
interface anchor_sequencer_if #(
   parameter int NUM_STAGES = 3
) ();
   logic                  start;
   logic                  abort;
   logic                  data_ready;
   logic [NUM_STAGES-1:0] stage_final;
   logic                  data_req;
   logic                  anchor_moving;
   logic [31:0]           anchor_x;
   logic [31:0]           anchor_y;
   logic                  busy;
   logic                  frame_done;

   // master: the pass controller and filter stages; slave: the sequencer
   modport master (
      output start, abort, data_ready, stage_final,
      input  data_req, anchor_moving, anchor_x, anchor_y, busy, frame_done
   );

   modport slave (
      input  start, abort, data_ready, stage_final,
      output data_req, anchor_moving, anchor_x, anchor_y, busy, frame_done
   );
endinterface

// File: rtl/anchor_sequencer.sv
// rtl/anchor_sequencer.sv - steps a processing window across the image row by row,
// handshaking window loads and waiting for all filter stages per anchor
module anchor_sequencer
   import edge_pkg::*;
#(
   parameter int IMAGE_W    = DEF_IMAGE_W,
   parameter int IMAGE_H    = DEF_IMAGE_H,
   parameter int STEP       = DEF_STEP,
   parameter int NUM_STAGES = 3
) (
   input  logic             clk,
   input  logic             n_rst,
   anchor_sequencer_if.slave bus
);

   anchor_state_t         state_q, state_d;
   logic [31:0]           x_q, x_d;
   logic [31:0]           y_q, y_d;
   logic [32:0]           step_sum;
   logic [NUM_STAGES-1:0] stage_flags;
   logic                  all_final;

   assign stage_flags = bus.stage_final;
   assign all_final   = &stage_flags;

   // widened so an anchor near 2^32 cannot wrap and look in-range
   assign step_sum = {1'b0, x_q} + 33'(STEP);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         x_q     <= 32'd0;
         y_q     <= 32'd0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      if (state_q != S_IDLE && bus.abort) begin
         state_d = S_IDLE;
         x_d     = 32'd0;
         y_d     = 32'd0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  state_d = S_LOAD;
                  x_d     = 32'd0;
                  y_d     = 32'd0;
               end
            end
            S_LOAD: begin
               if (bus.data_ready) state_d = S_MOVE;
            end
            S_MOVE:  state_d = S_GUARD;
            // stages still show final from the previous window here
            S_GUARD: state_d = S_WAIT_STAGES;
            S_WAIT_STAGES: begin
               if (all_final) begin
                  if (step_sum < 33'(IMAGE_W)) begin
                     x_d     = step_sum[31:0];
                     state_d = S_LOAD;
                  end else if (y_q < 32'(IMAGE_H - 1)) begin
                     x_d     = 32'd0;
                     y_d     = y_q + 32'd1;
                     state_d = S_LOAD;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign bus.data_req      = (state_q == S_LOAD);
   assign bus.anchor_moving = (state_q == S_MOVE);
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.frame_done    = (state_q == S_DONE);
   assign bus.anchor_x      = x_q;
   assign bus.anchor_y      = y_q;

endmodule

// File: doc/anchor_sequencer.md
ANCHOR_SEQUENCER -- requirements
Module: anchor_sequencer

Interface
REQ-001 SHALL have parameter IMAGE_W, default 640, image width in pixels (multiple of STEP).
REQ-002 SHALL have parameter IMAGE_H, default 480, image height in rows (>=1).
REQ-003 SHALL have parameter STEP, default 16, horizontal anchor advance per move in pixels.
REQ-004 SHALL have parameter NUM_STAGES, default 3, number of filter stages reporting completion.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 n_rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  begin one full-image pass; honoured only in IDLE.
REQ-008 abort  input  1  synchronous cancel of the current pass.
REQ-009 data_ready  input  1  input window for the current anchor is loaded.
REQ-010 stage_final  input  NUM_STAGES  per-stage "processing finished" flags (blur_final etc.).
REQ-011 data_req  output  1  request window fetch for current anchor; high throughout LOAD.
REQ-012 anchor_moving  output  1  one-cycle pulse telling stages to start on the new window.
REQ-013 anchor_x  output  32  current anchor column.
REQ-014 anchor_y  output  32  current anchor row.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  one-cycle pulse when the last anchor has been processed.

Function
REQ-017 States SHALL be IDLE, LOAD, MOVE, GUARD, WAIT_STAGES, DONE; all outputs registered or decoded from state only.
REQ-018 IDLE with start=1 SHALL go to LOAD and clear anchor_x, anchor_y to 0 on the same edge.
REQ-019 LOAD SHALL assert data_req and go to MOVE on the edge where data_ready=1.
REQ-020 MOVE SHALL assert anchor_moving for exactly one cycle, then go to GUARD.
REQ-021 GUARD SHALL last exactly one cycle ignoring stage_final (stages report final while idle), then go to WAIT_STAGES.
REQ-022 WAIT_STAGES SHALL leave only when every bit of stage_final is 1 in the same cycle.
REQ-023 On leaving WAIT_STAGES: if anchor_x+STEP < IMAGE_W, anchor_x += STEP, go to LOAD.
REQ-024 Else if anchor_y < IMAGE_H-1: anchor_x = 0, anchor_y += 1, go to LOAD (row wrap).
REQ-025 Else (last anchor): counters unchanged, go to DONE.
REQ-026 DONE SHALL assert frame_done for one cycle, then go to IDLE; anchor_x/anchor_y hold final values.
REQ-027 abort=1 in any non-IDLE state SHALL go to IDLE next edge with counters cleared; abort has priority over all other transitions; frame_done not asserted.
REQ-028 start while busy SHALL be ignored; start and abort together in IDLE: stay IDLE.
REQ-029 Anchor move to MOVE→anchor_moving latency from data_ready: 1 cycle; minimum anchor period 4 cycles.
REQ-030 Counter arithmetic SHALL be 32-bit unsigned; comparisons use widened sum, no overflow wrap.

Reset
REQ-031 On n_rst=0: state IDLE; anchor_x, anchor_y = 0; data_req, anchor_moving, busy, frame_done = 0.
REQ-032 Reset mid-pass SHALL abandon the pass with no frame_done; start required again.

Structure
REQ-033 State enum anchor_state_t and IMAGE_W/IMAGE_H/STEP defaults SHALL live in shared package edge_pkg.
REQ-034 No sub-module required; counters and FSM in one module; stage_final reduced with AND.

Verification (IMAGE_W=48, IMAGE_H=2, STEP=16, NUM_STAGES=3)
REQ-035 start, data_ready/stage_final=all-ones immediate -> 6 anchor_moving pulses at (0,0),(16,0),(32,0),(0,1),(16,1),(32,1), then one frame_done.
REQ-036 stage_final=3'b011 held 10 cycles then 3'b111 -> stays WAIT_STAGES, advances only on first all-ones cycle.
REQ-037 stage_final=3'b111 during GUARD only -> no advance; advance on later WAIT_STAGES all-ones.
REQ-038 abort in WAIT_STAGES at (16,1) -> IDLE next cycle, counters 0, busy 0, no frame_done.
REQ-039 n_rst low during LOAD -> all outputs 0 immediately; start afterwards restarts at (0,0).
REQ-040 start pulsed while busy -> no effect on counters or sequence.
